// File: rtl/video_timing_pkg.sv
// CEA-861 720x480p60 timing constants, raster-size helpers and the FSM state type
// shared by the HDMI video timing generator and its lock filter.
package video_timing_pkg;

  localparam int unsigned CEA_H_ACTIVE    = 720;
  localparam int unsigned CEA_H_FP        = 16;
  localparam int unsigned CEA_H_SYNC      = 62;
  localparam int unsigned CEA_H_BP        = 60;
  localparam int unsigned CEA_V_ACTIVE    = 480;
  localparam int unsigned CEA_V_FP        = 9;
  localparam int unsigned CEA_V_SYNC      = 6;
  localparam int unsigned CEA_V_BP        = 30;
  localparam int unsigned CEA_LOCK_STABLE = 1024;

  typedef enum logic {
    WAIT_LOCK = 1'b0,
    RUN       = 1'b1
  } state_e;

  function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lock_filter.sv
// Brings the PLL lock flag into the pixel clock domain and reports when it has been
// continuously high for LOCK_STABLE cycles.
module lock_filter
  import video_timing_pkg::*;
#(
  parameter int unsigned LOCK_STABLE = CEA_LOCK_STABLE
) (
  input  logic clk,
  input  logic rst,
  input  logic pll_locked_i,
  output logic lk_s_o,
  output logic lock_ok_o
);

  localparam int unsigned CW = cnt_width(LOCK_STABLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_STABLE - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lk_s;

  assign lk_s = sync_q[1];

  // Saturates at CNT_MAX so lock_ok stays up for as long as the lock holds.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    cnt_d = cnt_q;
    if (!lk_s) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops sample pre-edge values.
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], pll_locked_i};
      cnt_q  <= cnt_d;
    end
  end

  assign lk_s_o    = lk_s;
  assign lock_ok_o = lk_s && (cnt_q == CNT_MAX);

endmodule

// File: rtl/hdmi_video_timing.sv
// Raster timing generator: lock-gated FSM, h/v counters and a registered decode of
// sync, data-enable, pixel position and line/frame start pulses.
module hdmi_video_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = CEA_H_ACTIVE,
  parameter int unsigned H_FP        = CEA_H_FP,
  parameter int unsigned H_SYNC      = CEA_H_SYNC,
  parameter int unsigned H_BP        = CEA_H_BP,
  parameter int unsigned V_ACTIVE    = CEA_V_ACTIVE,
  parameter int unsigned V_FP        = CEA_V_FP,
  parameter int unsigned V_SYNC      = CEA_V_SYNC,
  parameter int unsigned V_BP        = CEA_V_BP,
  parameter bit          HS_POL      = 1'b0,
  parameter bit          VS_POL      = 1'b0,
  parameter int unsigned LOCK_STABLE = CEA_LOCK_STABLE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       running,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned HW      = cnt_width(H_TOTAL);
  localparam int unsigned VW      = cnt_width(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT    = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic lk_s, lock_ok;

  lock_filter #(
    .LOCK_STABLE (LOCK_STABLE)
  ) u_lock_filter (
    .clk          (clk),
    .rst          (rst),
    .pll_locked_i (pll_locked),
    .lk_s_o       (lk_s),
    .lock_ok_o    (lock_ok)
  );

  state_e        state_q, state_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;

  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = RUN;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end
      end
      RUN: begin
        // Losing lock aborts wherever the raster is; it restarts at (0,0) after relock.
        if (!lk_s) begin
          state_d = WAIT_LOCK;
          h_cnt_d = '0;
          v_cnt_d = '0;
        end else if (h_cnt_q == H_LAST) begin
          h_cnt_d = '0;
          v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
        end else begin
          h_cnt_d = h_cnt_q + HW'(1);
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    endcase
  end

  logic in_run, act, hs, vs, h_zero, v_zero;

  assign in_run = (state_q == RUN);
  assign h_zero = (h_cnt_q == '0);
  assign v_zero = (v_cnt_q == '0);
  assign act    = in_run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
  assign hs     = in_run && (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
  assign vs     = in_run && (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);

  logic       running_q, hsync_q, vsync_q, de_q, line_start_q, frame_start_q;
  logic [9:0] x_q, y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= WAIT_LOCK;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      running_q     <= 1'b0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      running_q     <= in_run;
      hsync_q       <= hs ? HS_POL : ~HS_POL;
      vsync_q       <= vs ? VS_POL : ~VS_POL;
      de_q          <= act;
      x_q           <= act ? 10'(h_cnt_q) : '0;
      y_q           <= act ? 10'(v_cnt_q) : '0;
      line_start_q  <= in_run && h_zero;
      frame_start_q <= in_run && h_zero && v_zero;
    end
  end

  assign running     = running_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
